// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, coordinate widths and colour type
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CNT_W     = 10;
  localparam int COORD_X_W = 10;
  localparam int COORD_Y_W = 9;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t FG_COLOR = 24'hFFFFFF;
  localparam rgb_t BG_COLOR = 24'h000000;

endpackage

// File: rtl/vga_scan_driver_if.sv
// rtl/vga_scan_driver_if.sv - renderer-facing coordinates plus VGA DAC pins
interface vga_scan_driver_if;
  import vga_pkg::*;

  logic                 render;
  logic [COORD_X_W-1:0] x;
  logic [COORD_Y_W-1:0] y;
  logic                 pix_en;
  logic                 frame_start;
  logic                 vga_clk;
  logic                 vga_hs;
  logic                 vga_vs;
  logic                 vga_blank_n;
  logic [7:0]           vga_r;
  logic [7:0]           vga_g;
  logic [7:0]           vga_b;

  modport master (
    input  render,
    output x, y, pix_en, frame_start,
    output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b
  );

  modport slave (
    output render,
    input  x, y, pix_en, frame_start,
    input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_scan_counter.sv
// rtl/vga_scan_counter.sv - pixel phase bit and horizontal/vertical scan counters
module vga_scan_counter #(
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      phase,
  output logic [vga_pkg::CNT_W-1:0] hcount,
  output logic [vga_pkg::CNT_W-1:0] vcount,
  output logic                      wrap
);

  localparam int CW = vga_pkg::CNT_W;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic h_last;
  logic v_last;

  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);
  // Asserted during the phase-1 clk whose edge takes the scan back to (0,0)
  assign wrap   = phase && h_last && v_last;

  // Phase alternates every clk, splitting each pixel into two clks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  // Counters step once per pixel, on the phase-1 edge; line advances on hcount wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (phase) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + CW'(1);
      end else begin
        hcount <= hcount + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA scan driver: sync decode, render capture, colour mux
module vga_scan_driver #(
  parameter int            H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int            H_FP     = vga_pkg::H_FP,
  parameter int            H_SYNC   = vga_pkg::H_SYNC,
  parameter int            H_BP     = vga_pkg::H_BP,
  parameter int            V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int            V_FP     = vga_pkg::V_FP,
  parameter int            V_SYNC   = vga_pkg::V_SYNC,
  parameter int            V_BP     = vga_pkg::V_BP,
  parameter vga_pkg::rgb_t FG_COLOR = vga_pkg::FG_COLOR,
  parameter vga_pkg::rgb_t BG_COLOR = vga_pkg::BG_COLOR
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_scan_driver_if.master bus
);

  localparam int CW = vga_pkg::CNT_W;
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          phase;
  logic          wrap;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;

  logic          active;
  logic          hs_next;
  logic          vs_next;
  vga_pkg::rgb_t rgb_next;

  logic          hs_q;
  logic          vs_q;
  logic          blank_q;
  vga_pkg::rgb_t rgb_q;
  logic          fs_q;
  logic          boot_q;

  vga_scan_counter #(
    .H_TOTAL (H_ACTIVE + H_FP + H_SYNC + H_BP),
    .V_TOTAL (V_ACTIVE + V_FP + V_SYNC + V_BP)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .phase   (phase),
    .hcount  (hcount),
    .vcount  (vcount),
    .wrap    (wrap)
  );

  // Decode sync/active for the pixel currently on x/y; render only matters inside the active area
  always_comb begin
    active   = (hcount < H_ACT) && (vcount < V_ACT);
    hs_next  = !((hcount >= HS_BEG) && (hcount < HS_END));
    vs_next  = !((vcount >= VS_BEG) && (vcount < VS_END));
    rgb_next = '0;
    if (active) begin
      rgb_next = bus.render ? FG_COLOR : BG_COLOR;
    end
  end

  // Pins load on the phase-1 edge from pre-advance counts, so they trail x/y by one pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else if (phase) begin
      hs_q    <= hs_next;
      vs_q    <= vs_next;
      blank_q <= active;
      rgb_q   <= rgb_next;
    end
  end

  // Wrap pulse lands on the next phase-0 clk; boot_q flags the very first clk out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs_q   <= 1'b0;
      boot_q <= 1'b1;
    end else begin
      fs_q   <= wrap;
      boot_q <= 1'b0;
    end
  end

  assign bus.x           = hcount;
  assign bus.y           = vcount[vga_pkg::COORD_Y_W-1:0];
  assign bus.pix_en      = phase;
  assign bus.vga_clk     = phase;
  // reset_n gate keeps the boot pulse low while reset is held
  assign bus.frame_start = fs_q | (boot_q & reset_n);
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_q;
  assign bus.vga_r       = rgb_q.r;
  assign bus.vga_g       = rgb_q.g;
  assign bus.vga_b       = rgb_q.b;

endmodule
